// File: rtl/wbdbgbus_pkg.sv
// Shared definitions for the debug-bus command path: opcodes, framing constants, deframer states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package wbdbgbus_pkg;

  // Command opcodes carried in the low nibble of the first frame byte
  localparam logic [3:0] CMD_READ_REQ     = 4'b0001;
  localparam logic [3:0] CMD_WRITE_REQ    = 4'b0010;
  localparam logic [3:0] CMD_SET_ADDR     = 4'b0011;
  localparam logic [3:0] CMD_SET_ADDR_INC = 4'b0111;

  // Framing
  localparam logic [7:0] RESET_TOKEN = 8'hFF;
  localparam int         FRAME_BYTES = 5;
  localparam int         CMD_W       = 36;

  // Deframer position: IDLE waits for a header byte, Bn waits for data byte n
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B1   = 3'd1,
    B2   = 3'd2,
    B3   = 3'd3,
    B4   = 3'd4
  } deframer_state_t;

  // A header byte has a zero upper nibble; anything else in IDLE is noise or the reset token
  function automatic logic is_header_byte(input logic [7:0] b);
    return (b[7:4] == 4'h0);
  endfunction

endpackage

// File: rtl/wbdbgbus_sync_fifo.sv
// Generic first-word-fall-through FIFO with synchronous flush and occupancy output.
// Latency: a push is visible at head_data/!empty the cycle after the write edge.
// Backpressure: push is ignored when full unless a pop happens on the same edge; flush beats push and pop.
module wbdbgbus_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head reads as zero when empty so the output is defined without resetting storage
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/wbdbgbus_cmd_deframer.sv
// Turns the UART RX byte stream into 36-bit debug-bus commands (5-byte frames) plus a bus-reset pulse.
// Latency: o_cmd_valid rises the cycle after the edge accepting the last frame byte (empty FIFO).
// Backpressure: commands wait in the FIFO while i_cmd_ready is low; a frame arriving to a full FIFO is dropped and o_overflow set.
// Optional WBDBGBUS_DEFRAMER_STATS_EN adds o_drop_count, a saturating count of dropped/ignored input.
module wbdbgbus_cmd_deframer
  import wbdbgbus_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx_valid,
  input  logic [7:0]         i_rx_data,
  output logic               o_cmd_valid,
  input  logic               i_cmd_ready,
  output logic [CMD_W-1:0]   o_cmd_data,
  output logic               o_cmd_reset,
  output logic               o_overflow,
  output logic [LEVEL_W-1:0] o_fifo_level
`ifdef WBDBGBUS_DEFRAMER_STATS_EN
  ,
  output logic [15:0]        o_drop_count
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  deframer_state_t state;
  deframer_state_t state_nxt;

  logic [3:0]       inst_q;
  logic [23:0]      data_q;
  logic [TW-1:0]    timer_q;
  logic             timer_expired;

  logic             frame_done;
  logic             token;
  logic             ignore_byte;
  logic             timeout;

  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_pop;
  logic             write_ok;
  logic [CMD_W-1:0] frame_word;

  assign timer_expired = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign frame_word    = {inst_q, data_q, i_rx_data};

  // The reset token flushes the FIFO, so a pop on that edge is suppressed
  assign o_cmd_valid = !fifo_empty;
  assign fifo_pop    = o_cmd_valid && i_cmd_ready && !token;
  assign write_ok    = frame_done && (!fifo_full || fifo_pop);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-byte event decode
  always_comb begin
    state_nxt   = state;
    frame_done  = 1'b0;
    token       = 1'b0;
    ignore_byte = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == RESET_TOKEN)       token       = 1'b1;
          else if (!is_header_byte(i_rx_data)) ignore_byte = 1'b1;
          else                                state_nxt   = B1;
        end
      end
      B1, B2, B3: begin
        if (i_rx_valid) begin
          state_nxt = deframer_state_t'(state + 3'd1);
        end else if (timer_expired) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      B4: begin
        if (i_rx_valid) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else if (timer_expired) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture header opcode and shift in the first three data bytes; the last byte goes straight to the FIFO
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inst_q <= '0;
      data_q <= '0;
    end else if (i_rx_valid) begin
      case (state)
        IDLE:       if (is_header_byte(i_rx_data)) inst_q <= i_rx_data[3:0];
        B1, B2, B3: data_q <= {data_q[15:0], i_rx_data};
        default:    ;
      endcase
    end
  end

  // Inter-byte idle timer: only runs inside a partial frame, restarts on every byte
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                     timer_q <= '0;
    else if (state == IDLE || i_rx_valid || timeout) timer_q <= '0;
    else                                           timer_q <= timer_q + TW'(1);
  end

  // Bus-reset pulse and sticky overflow flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cmd_reset <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_cmd_reset <= token;
      if (token)                        o_overflow <= 1'b0;
      else if (frame_done && !write_ok) o_overflow <= 1'b1;
    end
  end

  wbdbgbus_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .flush     (token),
    .push      (write_ok),
    .push_data (frame_word),
    .pop       (fifo_pop),
    .head_data (o_cmd_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (o_fifo_level)
  );

`ifdef WBDBGBUS_DEFRAMER_STATS_EN
  logic [15:0] drop_cnt;
  logic        drop_evt;

  assign drop_evt     = ignore_byte || timeout || (frame_done && !write_ok);
  assign o_drop_count = drop_cnt;

  // Saturating drop counter, cleared together with the bus by the reset token
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                               drop_cnt <= '0;
    else if (token)                          drop_cnt <= '0;
    else if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_wbdbgbus_cmd_deframer.sv
// Self-checking bench for wbdbgbus_cmd_deframer: directed vectors, corner sequences and a random run
// compared every cycle against a byte-queue reference model.
module tb_wbdbgbus_cmd_deframer;

  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_cmd_valid;
  logic        i_cmd_ready;
  logic [35:0] o_cmd_data;
  logic        o_cmd_reset;
  logic        o_overflow;
  logic [3:0]  o_fifo_level;

  wbdbgbus_cmd_deframer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .o_cmd_valid  (o_cmd_valid),
    .i_cmd_ready  (i_cmd_ready),
    .o_cmd_data   (o_cmd_data),
    .o_cmd_reset  (o_cmd_reset),
    .o_overflow   (o_overflow),
    .o_fifo_level (o_fifo_level)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: queued commands, bytes of the partial frame, idle count, flags
  logic [35:0] mq[$];
  logic [7:0]  part[$];
  int          idle_cnt = 0;
  bit          m_ovf    = 0;
  bit          m_pulse  = 0;

  typedef struct {
    logic [7:0]  b [5];
    logic [35:0] exp;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [35:0] ed;
    ed = (mq.size() > 0) ? mq[0] : 36'h0;
    check("cmd_valid", o_cmd_valid, (mq.size() > 0));
    check("cmd_data", o_cmd_data, ed);
    check("fifo_level", o_fifo_level, mq.size());
    check("overflow", o_overflow, m_ovf);
    check("cmd_reset", o_cmd_reset, m_pulse);
  endtask

  // One clock of the protocol rules, applied to the state before the edge
  task automatic model_step(input bit v, input logic [7:0] d, input bit rdy);
    bit          pop, tok, done;
    logic [35:0] w;
    pop = (mq.size() > 0) && rdy;
    tok = 0; done = 0; m_pulse = 0; w = '0;
    if (v) begin
      idle_cnt = 0;
      if (part.size() == 0) begin
        if (d == 8'hFF)          tok = 1;
        else if (d[7:4] == 4'h0) part.push_back(d);
      end else begin
        part.push_back(d);
        if (part.size() == 5) begin
          w = {part[0][3:0], part[1], part[2], part[3], part[4]};
          done = 1;
          part.delete();
        end
      end
    end else if (part.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == TMO) begin
        part.delete();
        idle_cnt = 0;
      end
    end
    if (tok) begin
      mq.delete();
      m_ovf = 0;
      m_pulse = 1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (done) begin
        if (mq.size() < DEPTH) mq.push_back(w);
        else                   m_ovf = 1;
      end
    end
  endtask

  // Compare the state produced by the previous edge, then drive the next edge's inputs
  task automatic cycle(input bit v, input logic [7:0] d, input bit rdy);
    @(negedge i_clk);
    compare_model();
    i_rx_valid  = v;
    i_rx_data   = d;
    i_cmd_ready = rdy;
    model_step(v, d, rdy);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input bit rdy);
    cycle(1, b0, rdy);
    cycle(1, b1, rdy);
    cycle(1, b2, rdy);
    cycle(1, b3, rdy);
    cycle(1, b4, rdy);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rx_valid = 0;
    i_rx_data  = 8'h00;
    i_rst      = 1;
    #1;
    check("rst_valid", o_cmd_valid, 0);
    check("rst_data", o_cmd_data, 0);
    check("rst_reset", o_cmd_reset, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_level", o_fifo_level, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 0;
    mq.delete(); part.delete();
    idle_cnt = 0; m_ovf = 0; m_pulse = 0;
    model_step(0, 8'h00, i_cmd_ready);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int  mode;
    bit  rdy, v;
    int  r, p;
    logic [7:0] b;

    vt[0].b = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}; vt[0].exp = 36'h1_DEADBEEF;
    vt[1].b = '{8'h07, 8'hFF, 8'hFF, 8'hFF, 8'hFF}; vt[1].exp = 36'h7_FFFFFFFF;
    vt[2].b = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00}; vt[2].exp = 36'h3_00001000;
    vt[3].b = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78}; vt[3].exp = 36'h2_12345678;
    vt[4].b = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h01}; vt[4].exp = 36'h0_80000001;

    i_rst = 1; i_rx_valid = 0; i_rx_data = 8'h00; i_cmd_ready = 0;
    do_reset();

    // Directed frames with ready high: valid one cycle after last byte, popped the next
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) cycle(1, vt[i].b[j], 1);
      cycle(0, 8'h00, 1);
      check("vec_valid", o_cmd_valid, 1);
      check("vec_data", o_cmd_data, vt[i].exp);
      cycle(0, 8'h00, 1);
      check("vec_level_after_pop", o_fifo_level, 0);
    end

    // Overflow: nine frames into an eight-entry FIFO with ready low
    for (int k = 0; k < 9; k++) send_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'(k), 0);
    cycle(0, 8'h00, 0);
    check("ovf_level", o_fifo_level, DEPTH);
    check("ovf_flag", o_overflow, 1);
    for (int k = 0; k < 8; k++) begin
      check("ovf_order", o_cmd_data, {4'h2, 32'(k)});
      cycle(0, 8'h00, 1);
      cycle(0, 8'h00, 0);
    end
    check("ovf_drained", o_cmd_valid, 0);
    check("ovf_sticky", o_overflow, 1);

    // Timeout discards a stale partial frame
    cycle(1, 8'h03, 0); cycle(1, 8'h12, 0); cycle(1, 8'h34, 0);
    repeat (TMO + 3) cycle(0, 8'h00, 0);
    send_frame(8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 0);
    cycle(0, 8'h00, 0);
    check("tmo_level", o_fifo_level, 1);
    check("tmo_data", o_cmd_data, 36'h3_00001000);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);

    // One idle cycle short of the timeout keeps the frame alive
    cycle(1, 8'h01, 0); cycle(1, 8'h00, 0); cycle(1, 8'h00, 0);
    repeat (TMO - 1) cycle(0, 8'h00, 0);
    cycle(1, 8'h00, 0); cycle(1, 8'h05, 0);
    cycle(0, 8'h00, 0);
    check("tmo_edge_level", o_fifo_level, 1);
    check("tmo_edge_data", o_cmd_data, 36'h1_00000005);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);

    // Reset token flushes queued commands and clears overflow
    for (int k = 0; k < 3; k++) send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'(k), 0);
    cycle(0, 8'h00, 0);
    check("tok_pre_level", o_fifo_level, 3);
    check("tok_pre_ovf", o_overflow, 1);
    cycle(1, 8'hFF, 1);
    cycle(0, 8'h00, 0);
    check("tok_pulse", o_cmd_reset, 1);
    check("tok_level", o_fifo_level, 0);
    check("tok_valid", o_cmd_valid, 0);
    check("tok_ovf", o_overflow, 0);
    cycle(0, 8'h00, 0);
    check("tok_pulse_end", o_cmd_reset, 0);

    // Stray byte in IDLE is ignored; 0xFF inside a frame is plain data
    cycle(1, 8'h5A, 1);
    cycle(0, 8'h00, 1);
    check("stray_level", o_fifo_level, 0);
    send_frame(8'h07, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
    cycle(0, 8'h00, 0);
    check("ff_data", o_cmd_data, 36'h7_FFFFFFFF);
    check("ff_no_pulse", o_cmd_reset, 0);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);

    // Asynchronous reset mid-frame loses the partial frame
    send_frame(8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 0);
    cycle(1, 8'h01, 0); cycle(1, 8'h99, 0); cycle(1, 8'h88, 0);
    do_reset();
    send_frame(8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 0);
    cycle(0, 8'h00, 0);
    check("rst_mid_level", o_fifo_level, 1);
    check("rst_mid_data", o_cmd_data, 36'h2_11223344);
    cycle(0, 8'h00, 1);

    // Random traffic against the model
    mode = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) mode = $urandom_range(0, 2);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
      r = $urandom_range(0, 999);
      if (r < 3) begin
        do_reset();
      end else if (r < 13) begin
        repeat ($urandom_range(TMO - 2, TMO + 2)) cycle(0, 8'h00, rdy);
      end else begin
        v = 1'($urandom_range(0, 1));
        if (part.size() == 0) begin
          p = $urandom_range(0, 99);
          if (p < 80)      b = {4'h0, 4'($urandom_range(0, 15))};
          else if (p < 85) b = 8'hFF;
          else             b = 8'($urandom_range(16, 254));
        end else begin
          b = 8'($urandom_range(0, 255));
        end
        cycle(v, b, rdy);
      end
    end
    cycle(0, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
